// File: rtl/video_htiming_gen.sv
// Horizontal video timing generator: pixel counter, level/pulse events and
// double-buffered timing registers that take effect at the start of each line.
module video_htiming_gen #(
  parameter int unsigned CW           = 10,
  parameter int unsigned FETCH_FOREGO = 18,
  parameter int unsigned TEXT_ADVANCE = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cend_i,
  input  logic          pre_cend_i,
  input  logic          init_i,
  input  logic          mode_a_text_i,
  input  logic          wr_en_i,
  input  logic [2:0]    wr_addr_i,
  input  logic [CW-1:0] wr_data_i,
  output logic          hblank_o,
  output logic          hsync_o,
  output logic          hpix_o,
  output logic          line_start_o,
  output logic          hsync_start_o,
  output logic          hint_start_o,
  output logic          fetch_start_o,
  output logic          fetch_end_o,
  output logic [CW-1:0] hcount_o
);

  localparam int NumRegs = 7;
  localparam logic [CW:0] FetchLead = (CW+1)'(FETCH_FOREGO);
  localparam logic [CW:0] TextLead  = (CW+1)'(FETCH_FOREGO + TEXT_ADVANCE);

  function automatic logic [CW-1:0] reset_val(input int idx);
    case (idx)
      0:       return CW'(448);
      1:       return CW'(10);
      2:       return CW'(43);
      3:       return CW'(88);
      4:       return CW'(140);
      5:       return CW'(396);
      default: return CW'(443);
    endcase
  endfunction

  // Targets at or beyond the line length can never be reached.
  function automatic logic at_pos(input logic [CW:0] tgt, input logic [CW-1:0] pos,
                                  input logic [CW-1:0] period);
    return (tgt < {1'b0, period}) && (tgt == {1'b0, pos});
  endfunction

  function automatic logic [CW:0] sub_mod(input logic [CW-1:0] a, input logic [CW:0] b,
                                          input logic [CW-1:0] period);
    logic [CW:0] d;
    d = {1'b0, a} - b;
    if ({1'b0, a} < b) d = d + {1'b0, period};
    return d;
  endfunction

  logic [CW-1:0] shadow_q [NumRegs];
  logic [CW-1:0] shadow_d [NumRegs];
  logic [CW-1:0] active_q [NumRegs];
  logic [CW-1:0] active_d [NumRegs];
  logic [CW-1:0] hcount_q, hcount_d;
  logic          hblank_q, hblank_d, hsync_q, hsync_d, hpix_q, hpix_d;
  logic [4:0]    pulse_q, pulse_d;

  logic [CW-1:0] period, hsync_beg, hsync_end, hblnk_end, hpix_beg, hpix_end, hint_beg;
  logic          wrap;
  logic [CW:0]   fetch_start_tgt, fetch_end_tgt;

  assign period    = active_q[0];
  assign hsync_beg = active_q[1];
  assign hsync_end = active_q[2];
  assign hblnk_end = active_q[3];
  assign hpix_beg  = active_q[4];
  assign hpix_end  = active_q[5];
  assign hint_beg  = active_q[6];

  assign wrap            = init_i || (hcount_q == period - CW'(1));
  assign fetch_start_tgt = sub_mod(hpix_beg, mode_a_text_i ? TextLead : FetchLead, period);
  assign fetch_end_tgt   = sub_mod(hpix_end, FetchLead, period);

  always_comb begin
    shadow_d = shadow_q;
    if (wr_en_i && (wr_addr_i != 3'd7) && !((wr_addr_i == 3'd0) && (wr_data_i < CW'(4)))) begin
      shadow_d[wr_addr_i] = wr_data_i;
    end
  end

  always_comb begin
    active_d = active_q;
    hcount_d = hcount_q;
    hblank_d = hblank_q;
    hsync_d  = hsync_q;
    hpix_d   = hpix_q;
    if (cend_i) begin
      // Commit uses the shadow as it stood before this clk's write.
      if (wrap) active_d = shadow_q;
      hcount_d = wrap ? '0 : hcount_q + CW'(1);
      if (at_pos('0, hcount_q, period))                      hblank_d = 1'b1;
      else if (at_pos({1'b0, hblnk_end}, hcount_q, period))  hblank_d = 1'b0;
      if (at_pos({1'b0, hsync_beg}, hcount_q, period))       hsync_d  = 1'b1;
      else if (at_pos({1'b0, hsync_end}, hcount_q, period))  hsync_d  = 1'b0;
      if (at_pos({1'b0, hpix_beg}, hcount_q, period))        hpix_d   = 1'b1;
      else if (at_pos({1'b0, hpix_end}, hcount_q, period))   hpix_d   = 1'b0;
    end
  end

  always_comb begin
    pulse_d    = '0;
    pulse_d[0] = pre_cend_i && at_pos({1'b0, hblnk_end}, hcount_q, period);
    pulse_d[1] = pre_cend_i && at_pos({1'b0, hsync_beg}, hcount_q, period);
    pulse_d[2] = pre_cend_i && at_pos({1'b0, hint_beg}, hcount_q, period);
    pulse_d[3] = pre_cend_i && at_pos(fetch_start_tgt, hcount_q, period);
    pulse_d[4] = pre_cend_i && at_pos(fetch_end_tgt, hcount_q, period);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hcount_q <= '0;
      hblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      hpix_q   <= 1'b0;
      pulse_q  <= '0;
      for (int i = 0; i < NumRegs; i++) begin
        shadow_q[i] <= reset_val(i);
        active_q[i] <= reset_val(i);
      end
    end else begin
      hcount_q <= hcount_d;
      hblank_q <= hblank_d;
      hsync_q  <= hsync_d;
      hpix_q   <= hpix_d;
      pulse_q  <= pulse_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign hcount_o      = hcount_q;
  assign hblank_o      = hblank_q;
  assign hsync_o       = hsync_q;
  assign hpix_o        = hpix_q;
  assign line_start_o  = pulse_q[0];
  assign hsync_start_o = pulse_q[1];
  assign hint_start_o  = pulse_q[2];
  assign fetch_start_o = pulse_q[3];
  assign fetch_end_o   = pulse_q[4];

endmodule

// File: doc/video_htiming_gen.md
VIDEO_HTIMING_GEN -- requirements
Module: video_htiming_gen

Interface
REQ-001 SHALL have parameter CW, default 10, meaning horizontal counter and timing register width in bits.
REQ-002 SHALL have parameter FETCH_FOREGO, default 18, meaning cend cycles by which fetch_start/fetch_end precede the hpix edges.
REQ-003 SHALL have parameter TEXT_ADVANCE, default 4, meaning extra cend cycles of fetch_start lead when mode_a_text=1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port cend, input, 1 bit: 7 MHz pixel-cycle strobe.
REQ-007 SHALL have port pre_cend, input, 1 bit: strobe one clk before cend.
REQ-008 SHALL have port init, input, 1 bit: phase reset, sampled when cend=1.
REQ-009 SHALL have port mode_a_text, input, 1 bit: text-mode fetch lead select.
REQ-010 SHALL have port wr_en, input, 1 bit: timing register write strobe.
REQ-011 SHALL have port wr_addr, input, 3 bits: timing register index.
REQ-012 SHALL have port wr_data, input, CW bits: timing register write data.
REQ-013 SHALL have outputs hblank, hsync and hpix, 1 bit each: level outputs.
REQ-014 SHALL have outputs line_start, hsync_start, hint_start, fetch_start and fetch_end, 1 bit each: one-clk pulses that coincide with cend.
REQ-015 SHALL have output hcount, CW bits: current horizontal position.

Function
REQ-016 SHALL hold seven timing registers, each with a shadow copy and an active copy: 0 PERIOD, 1 HSYNC_BEG, 2 HSYNC_END, 3 HBLNK_END, 4 HPIX_BEG, 5 HPIX_END, 6 HINT_BEG.
REQ-017 SHALL write wr_data to shadow[wr_addr] on any clk where wr_en=1, independent of cend; writes to address 7 are ignored, and writes of PERIOD<4 are ignored.
REQ-018 SHALL commit all shadow registers to active at the cend where hcount wraps to 0 (hcount==PERIOD-1, or init=1); a write in the same clk as the commit misses that commit and takes effect at the next line.
REQ-019 SHALL, on cend, load hcount with 0 when init=1 or hcount==PERIOD-1, and otherwise increment it; hcount SHALL NOT change when cend=0.
REQ-020 SHALL, on cend, set hblank at hcount==0 and clear it at hcount==HBLNK_END; set takes priority when both match.
REQ-021 SHALL, on cend, set hsync at HSYNC_BEG and clear it at HSYNC_END; set takes priority.
REQ-022 SHALL, on cend, set hpix at HPIX_BEG and clear it at HPIX_END; set takes priority.
REQ-023 SHALL generate each pulse output by registering (pre_cend && hcount==T), so the pulse is high exactly during the following cend clk; otherwise the output is 0.
REQ-024 SHALL use T=HSYNC_BEG for hsync_start, T=HBLNK_END for line_start and T=HINT_BEG for hint_start.
REQ-025 SHALL use T=HPIX_BEG-FETCH_FOREGO for fetch_start when mode_a_text=0, and T=HPIX_BEG-FETCH_FOREGO-TEXT_ADVANCE when mode_a_text=1.
REQ-026 SHALL use T=HPIX_END-FETCH_FOREGO for fetch_end.
REQ-027 SHALL compute all subtractions modulo PERIOD: a negative result has PERIOD added, and the arithmetic is done at CW+1 bits.
REQ-028 SHALL never match a comparison whose target is >=PERIOD, so the corresponding event never fires.
REQ-029 SHALL treat mode_a_text as combinational and effective from the next pre_cend.

Reset
REQ-030 SHALL, when rst_n=0 at a clk edge, set hcount=0, all level outputs=0 and all pulse outputs=0, regardless of cend.
REQ-031 SHALL, on reset, load both shadow and active registers with PERIOD=448, HSYNC_BEG=10, HSYNC_END=43, HBLNK_END=88, HPIX_BEG=140, HPIX_END=396, HINT_BEG=443.
REQ-032 SHALL, on reset asserted mid-line, discard any pending shadow writes.

Verification
REQ-033 SHALL cover defaults with cend every 2 clk: hblank 0..87, hsync 10..42, hpix 140..395, line_start at hcount 88, hint_start at 443, and a period of 448 cend.
REQ-034 SHALL cover fetch timing: mode_a_text=0 gives fetch_start at hcount 122; mode_a_text=1 gives it at 118; fetch_end occurs at 378.
REQ-035 SHALL cover a mid-line write of PERIOD=512 and HPIX_END=460: the current line still wraps at 447, and the next line wraps at 511 with hpix clearing at 460.
REQ-036 SHALL cover the wrap case: HPIX_BEG=10 gives fetch_start at hcount 440 of the previous line (10-18+448).
REQ-037 SHALL cover init=1 at hcount 200 with cend: hcount becomes 0, shadow values commit, and hblank sets on the next cend.
REQ-038 SHALL cover rst_n=0 mid-line: all outputs read 0 on the next clk, and after release the default timing from REQ-033 is reproduced.
